// File: rtl/binary_to_bcd_serial.sv
// Serial shift-and-add-3 binary to BCD converter, one bit per clock.
// Produces four registered digits with a start/done handshake and saturation above 9999.
module binary_to_bcd_serial #(
    parameter int WIDTH = 14
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] binary,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [3:0]       num1,
    output logic [3:0]       num2,
    output logic [3:0]       num3,
    output logic [3:0]       num4
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    localparam logic [4:0] CNT_LOAD = 5'(WIDTH);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_shift;
    logic [15:0]      r_bcd;
    logic [4:0]       r_cnt;
    logic             r_ovf_pend;
    logic             r_done;
    logic             r_ovf;
    logic [3:0]       r_num1;
    logic [3:0]       r_num2;
    logic [3:0]       r_num3;
    logic [3:0]       r_num4;

    logic [14:0]      w_adj;
    logic [4:0]       w_cnt_next;
    logic             w_ovf_in;

    // Top nibble only feeds bits [2:0] forward; its MSB is shifted out.
    always_comb begin
        w_adj = '0;
        for (int i = 0; i < 3; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            else
                w_adj[4*i +: 4] = r_bcd[4*i +: 4];
        end
        if (r_bcd[15:12] >= 4'd5)
            w_adj[14:12] = r_bcd[14:12] + 3'd3;
        else
            w_adj[14:12] = r_bcd[14:12];
    end

    assign w_cnt_next = r_cnt - 5'd1;
    assign w_ovf_in   = 32'(binary) > 32'd9999;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_num1     <= '0;
            r_num2     <= '0;
            r_num3     <= '0;
            r_num4     <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shift    <= binary;
                        r_bcd      <= '0;
                        r_cnt      <= CNT_LOAD;
                        r_ovf_pend <= w_ovf_in;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_bcd   <= {w_adj, r_shift[WIDTH-1]};
                    r_shift <= r_shift << 1;
                    r_cnt   <= w_cnt_next;
                    if (w_cnt_next == 5'd0)
                        r_state <= FINISH;
                end
                FINISH: begin
                    if (r_ovf_pend) begin
                        r_num1 <= 4'd9;
                        r_num2 <= 4'd9;
                        r_num3 <= 4'd9;
                        r_num4 <= 4'd9;
                        r_ovf  <= 1'b1;
                    end else begin
                        r_num1 <= r_bcd[3:0];
                        r_num2 <= r_bcd[7:4];
                        r_num3 <= r_bcd[11:8];
                        r_num4 <= r_bcd[15:12];
                        r_ovf  <= 1'b0;
                    end
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign overflow = r_ovf;
    assign num1     = r_num1;
    assign num2     = r_num2;
    assign num3     = r_num3;
    assign num4     = r_num4;

endmodule

// File: tb/tb_binary_to_bcd_serial.sv
// Directed bench for binary_to_bcd_serial: latency, digits, saturation,
// back-to-back starts and asynchronous abort.
module tb_binary_to_bcd_serial;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [13:0] binary;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [3:0]  num1;
    logic [3:0]  num2;
    logic [3:0]  num3;
    logic [3:0]  num4;

    int tests_run;
    int tests_failed;

    binary_to_bcd_serial #(.WIDTH(14)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .binary   (binary),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .num1     (num1),
        .num2     (num2),
        .num3     (num3),
        .num4     (num4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        if (v > 9999) begin
            r = 16'h9999;
        end else begin
            r[15:12] = 4'(v / 1000);
            r[11:8]  = 4'((v / 100) % 10);
            r[7:4]   = 4'((v / 10) % 10);
            r[3:0]   = 4'(v % 10);
        end
        return r;
    endfunction

    // Stimulus driver: one conversion, returns latency in edges after E0
    // (0 on timeout), busy cycle count and captured outputs.
    task automatic run_conv(input logic [13:0] v, output int lat,
                            output int bcnt, output logic [15:0] dig,
                            output logic ovf);
        lat  = 0;
        bcnt = 0;
        dig  = 16'hxxxx;
        ovf  = 1'bx;
        @(negedge clock);
        binary = v;
        start  = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        if (busy) bcnt++;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (done) begin
                lat = k;
                dig = {num4, num3, num2, num1};
                ovf = overflow;
                break;
            end
            if (busy) bcnt++;
        end
    endtask

    task automatic test_reset();
        int lat, bcnt;
        logic [15:0] dig;
        logic ovf;
        reset_n = 1'b0;
        binary  = 14'd1234;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            start = ~start;
        end
        @(negedge clock);
        start = 1'b0;
        tests_run++;
        if ({busy, done, overflow} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b want 000", {busy, done, overflow});
        end
        tests_run++;
        if ({num4, num3, num2, num1} !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_digits: got %h want 0000", {num4, num3, num2, num1});
        end
        reset_n = 1'b1;
        run_conv(14'd0, lat, bcnt, dig, ovf);
        tests_run++;
        if (lat !== 15 || dig !== 16'h0000 || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL conv_0: got lat=%0d dig=%h ovf=%b want lat=15 dig=0000 ovf=0", lat, dig, ovf);
        end
    endtask

    task automatic test_convert();
        int lat, bcnt;
        logic [15:0] dig;
        logic ovf;
        logic [13:0] vals [3] = '{14'd1234, 14'd9999, 14'd5};
        logic [15:0] exps [3] = '{16'h1234, 16'h9999, 16'h0005};
        for (int i = 0; i < 3; i++) begin
            run_conv(vals[i], lat, bcnt, dig, ovf);
            tests_run++;
            if (lat !== 15 || bcnt !== 15) begin
                tests_failed++;
                $display("FAIL conv_timing %0d: got lat=%0d busy=%0d want 15/15", vals[i], lat, bcnt);
            end
            tests_run++;
            if (dig !== exps[i] || ovf !== 1'b0) begin
                tests_failed++;
                $display("FAIL conv_value %0d: got %h ovf=%b want %h ovf=0", vals[i], dig, ovf, exps[i]);
            end
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_in_done: got %b want 0", busy);
        end
    endtask

    task automatic test_overflow();
        int lat, bcnt;
        logic [15:0] dig;
        logic ovf;
        logic [13:0] vals [3] = '{14'd10000, 14'd16383, 14'd42};
        logic [16:0] exps [3] = '{17'h19999, 17'h19999, 17'h00042};
        for (int i = 0; i < 3; i++) begin
            run_conv(vals[i], lat, bcnt, dig, ovf);
            tests_run++;
            if (lat !== 15 || {ovf, dig} !== exps[i]) begin
                tests_failed++;
                $display("FAIL ovf_conv %0d: got lat=%0d ovf/dig=%h want lat=15 %h", vals[i], lat, {ovf, dig}, exps[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int c1, c2, ndone;
        logic [15:0] d1, d2;
        c1 = 0; c2 = 0; ndone = 0;
        d1 = 16'hxxxx; d2 = 16'hxxxx;
        @(negedge clock);
        binary = 14'd1234;
        start  = 1'b1;
        @(posedge clock);
        #1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clock);
            #1;
            if (c == 3) binary = 14'd777;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    c1 = c;
                    d1 = {num4, num3, num2, num1};
                end else if (ndone == 2) begin
                    c2 = c;
                    d2 = {num4, num3, num2, num1};
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        tests_run++;
        if (c1 !== 15 || d1 !== 16'h1234) begin
            tests_failed++;
            $display("FAIL b2b_first: got c=%0d dig=%h want c=15 dig=1234", c1, d1);
        end
        tests_run++;
        if (c2 - c1 !== 16 || d2 !== 16'h0777) begin
            tests_failed++;
            $display("FAIL b2b_second: got gap=%0d dig=%h want gap=16 dig=0777", c2 - c1, d2);
        end
        tests_run++;
        if (ndone !== 2) begin
            tests_failed++;
            $display("FAIL b2b_done_count: got %0d want 2", ndone);
        end
    endtask

    task automatic test_reset_abort();
        int lat, bcnt, ndone;
        logic [15:0] dig;
        logic ovf;
        ndone = 0;
        @(negedge clock);
        binary = 14'd8765;
        start  = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, overflow, num4, num3, num2, num1} !== 19'h0) begin
            tests_failed++;
            $display("FAIL abort_zero: got %h want 00000", {busy, done, overflow, num4, num3, num2, num1});
        end
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clock);
            #1;
            if (done) ndone++;
        end
        tests_run++;
        if (ndone !== 0) begin
            tests_failed++;
            $display("FAIL abort_no_done: got %0d want 0", ndone);
        end
        run_conv(14'd321, lat, bcnt, dig, ovf);
        tests_run++;
        if (lat !== 15 || dig !== 16'h0321 || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL after_abort: got lat=%0d dig=%h ovf=%b want 15 0321 0", lat, dig, ovf);
        end
    endtask

    task automatic test_sweep();
        int lat, bcnt, v;
        logic [15:0] dig;
        logic ovf;
        logic [16:0] exp;
        for (int i = 0; i < 160; i++) begin
            case (i)
                0: v = 9998;
                1: v = 10001;
                2: v = 999;
                3: v = 8191;
                default: v = int'($urandom_range(0, 16383));
            endcase
            exp = {(v > 9999), ref_bcd(v)};
            run_conv(14'(v), lat, bcnt, dig, ovf);
            tests_run++;
            if (lat !== 15 || {ovf, dig} !== exp) begin
                tests_failed++;
                $display("FAIL sweep %0d: got lat=%0d ovf/dig=%h want lat=15 %h", v, lat, {ovf, dig}, exp);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        start        = 1'b0;
        binary       = '0;
        test_reset();
        test_convert();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
